// File: rtl/pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_rr_arbiter
//   Shares one packet destination between NUM_SRC packet sources. Arbitration
//   is round-robin, with a bounded burst: a source may be granted up to
//   MAX_BURST packets in a row before the grant is forced to rotate. Each
//   accepted packet is held in a single registered slot until the destination
//   takes it, so there is one IDLE bubble between consecutive packets.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst         in   synchronous active-high reset
//   src_valid   in   [NUM_SRC]        per-source packet valid
//   src_packet  in   [NUM_SRC*PKT_W]  source i at [i*PKT_W +: PKT_W]
//   src_ready   out  [NUM_SRC]        per-source accept, one-hot or zero
//   dd_valid    out                   output slot holds a packet
//   dd_ready    in                    destination accepts the packet
//   packet      out  [PKT_W]          packet presented to the destination
//   grant_id    out  [ID_W]           source index of the packet in the slot
//   busy        out                   high while the slot is occupied (SEND)
// -----------------------------------------------------------------------------
module pkt_rr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int PKT_W     = 13,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*PKT_W-1:0] src_packet,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic                     dd_valid,
    input  logic                     dd_ready,
    output logic [PKT_W-1:0]         packet,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [0:0]      IDLE   = 1'b0;
    localparam logic [0:0]      SEND   = 1'b1;
    localparam logic [BW-1:0]   MAX_B  = BW'(MAX_BURST);
    localparam logic [BW-1:0]   ONE_B  = BW'(1);
    localparam logic [ID_W-1:0] LAST_R = ID_W'(NUM_SRC - 1);

    logic [0:0]       state_q;
    logic [PKT_W-1:0] packet_q;
    logic [ID_W-1:0]  grant_q;
    logic [ID_W-1:0]  last_q;
    logic [BW-1:0]    burst_q;

    logic             any_valid_s;
    logic             burst_cont_s;
    logic             rr_found_s;
    logic [ID_W-1:0]  rr_idx_s;
    logic [ID_W-1:0]  cand_s;
    logic [ID_W-1:0]  winner_s;
    logic [BW-1:0]    burst_d;
    logic [PKT_W-1:0] pkt_sel_s;

    // Winner selection: burst continuation first, otherwise a round-robin
    // search starting just after the last granted source. The search ends at
    // last_q itself, so a lone requester re-wins with its burst restarted.
    always_comb begin
        any_valid_s  = |src_valid;
        burst_cont_s = (burst_q != '0) && (burst_q < MAX_B) && src_valid[last_q];
        rr_found_s   = 1'b0;
        rr_idx_s     = last_q;
        cand_s       = last_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_s = ID_W'((int'(last_q) + k) % NUM_SRC);
            if (!rr_found_s && src_valid[cand_s]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        if (burst_cont_s) begin
            winner_s = last_q;
            burst_d  = burst_q + ONE_B;
        end else begin
            winner_s = rr_idx_s;
            burst_d  = ONE_B;
        end
    end

    // Packet mux for the winning source (AND-OR so no priority chain).
    always_comb begin
        pkt_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_sel_s = pkt_sel_s |
                ({PKT_W{winner_s == ID_W'(i)}} & src_packet[i*PKT_W +: PKT_W]);
        end
    end

    // Accept strobe: only in IDLE and never during reset; independent of dd_ready.
    always_comb begin
        if (!rst && (state_q == IDLE) && any_valid_s) begin
            src_ready = NUM_SRC'(1) << winner_s;
        end else begin
            src_ready = '0;
        end
    end

    // FSM and output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            packet_q <= '0;
            grant_q  <= '0;
            last_q   <= LAST_R;
            burst_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid_s) begin
                        packet_q <= pkt_sel_s;
                        grant_q  <= winner_s;
                        last_q   <= winner_s;
                        burst_q  <= burst_d;
                        state_q  <= SEND;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SEND: begin
                    if (dd_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= SEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dd_valid = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign packet   = packet_q;
    assign grant_id = grant_q;

endmodule
